pipeline_stall_unit: RTL and testbench

Central stall/flush controller for the 5-stage RV32I pipeline. It tracks outstanding instruction- and data-memory requests, combines them into one pipeline-advance decision, and drives the load enables of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It also inserts bubbles on a taken control transfer resolved in EX. Its outputs directly gate the ID/EX, EX/MEM and MEM/WB registers, which are the registers the forwarding logic consumes.

---
 rtl/pipeline_stall_unit_pkg.sv | 12 +
 rtl/pipeline_stall_unit_if.sv | 44 ++++
 rtl/pipeline_stall_unit_mem_stall_tracker.sv | 42 ++++
 rtl/pipeline_stall_unit.sv | 82 ++++++++
 tb/tb_pipeline_stall_unit.sv | 138 +++++++++++++
 5 files changed

// File: rtl/pipeline_stall_unit_pkg.sv
// Shared types for the pipeline stall/flush controller: memory tracker state and counter width.
package pipeline_stall_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_trk_state_t;

  localparam int CTR_W = 32;

endpackage

// File: rtl/pipeline_stall_unit_if.sv
// Handshake bundle between the RV32I datapath (master) and the stall/flush controller (slave).
interface pipeline_stall_unit_if;
  import pipeline_stall_unit_pkg::*;

  logic             imem_read;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             ex_redirect;
  logic             pc_ld;
  logic             pc_redirect;
  logic             ifid_ld;
  logic             idex_ld;
  logic             exmem_ld;
  logic             memwb_ld;
  logic             ifid_flush;
  logic             idex_flush;
  logic             imem_req_mask;
  logic             dmem_req_mask;
  logic             imem_hold_ld;
  logic             dmem_hold_ld;
  logic             imem_use_hold;
  logic             dmem_use_hold;
  logic [CTR_W-1:0] stall_cycles_i;
  logic [CTR_W-1:0] stall_cycles_d;
  logic [CTR_W-1:0] flush_count;

  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp, ex_redirect,
    input  pc_ld, pc_redirect, ifid_ld, idex_ld, exmem_ld, memwb_ld,
    input  ifid_flush, idex_flush, imem_req_mask, dmem_req_mask,
    input  imem_hold_ld, dmem_hold_ld, imem_use_hold, dmem_use_hold,
    input  stall_cycles_i, stall_cycles_d, flush_count
  );

  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp, ex_redirect,
    output pc_ld, pc_redirect, ifid_ld, idex_ld, exmem_ld, memwb_ld,
    output ifid_flush, idex_flush, imem_req_mask, dmem_req_mask,
    output imem_hold_ld, dmem_hold_ld, imem_use_hold, dmem_use_hold,
    output stall_cycles_i, stall_cycles_d, flush_count
  );

endinterface

// File: rtl/pipeline_stall_unit_mem_stall_tracker.sv
// Per-port outstanding-request tracker: IDLE/WAIT/DONE, with busy and hold-register controls.
module mem_stall_tracker
  import pipeline_stall_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic resp,
  input  logic advance,
  output logic busy,
  output logic hold_ld,
  output logic use_hold,
  output logic req_mask
);

  mem_trk_state_t state, state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A completion while the other port still stalls parks the data in DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req && !resp) state_nx = WAIT;
      WAIT:    if (resp) state_nx = advance ? IDLE : DONE;
      DONE:    if (advance) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy must not depend on advance, otherwise advance would loop on itself.
  always_comb begin
    busy     = ((state == IDLE) && req && !resp) || ((state == WAIT) && !resp);
    hold_ld  = !rst && (state == WAIT) && resp && !advance;
    use_hold = !rst && (state == DONE);
    req_mask = !rst && (state == DONE);
  end

endmodule

// File: rtl/pipeline_stall_unit.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Optional performance counters are built when PERF_CTR_EN is defined.
module pipeline_stall_unit
  import pipeline_stall_unit_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  pipeline_stall_unit_if.slave bus
);

  logic ibusy;
  logic dbusy;
  logic advance;
  logic run;
  logic redirect_take;

  mem_stall_tracker u_imem_trk (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.imem_read),
    .resp     (bus.imem_resp),
    .advance  (advance),
    .busy     (ibusy),
    .hold_ld  (bus.imem_hold_ld),
    .use_hold (bus.imem_use_hold),
    .req_mask (bus.imem_req_mask)
  );

  mem_stall_tracker u_dmem_trk (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.dmem_req),
    .resp     (bus.dmem_resp),
    .advance  (advance),
    .busy     (dbusy),
    .hold_ld  (bus.dmem_hold_ld),
    .use_hold (bus.dmem_use_hold),
    .req_mask (bus.dmem_req_mask)
  );

  // A redirect is only honoured when the whole pipeline moves; otherwise the
  // control instruction simply waits in EX.
  assign advance       = !ibusy && !dbusy;
  assign run           = advance && !rst;
  assign redirect_take = run && bus.ex_redirect;

  assign bus.pc_ld       = run;
  assign bus.ifid_ld     = run;
  assign bus.idex_ld     = run;
  assign bus.exmem_ld    = run;
  assign bus.memwb_ld    = run;
  assign bus.pc_redirect = redirect_take;
  assign bus.ifid_flush  = redirect_take;
  assign bus.idex_flush  = redirect_take;

`ifdef PERF_CTR_EN
  logic [CTR_W-1:0] stall_i_q;
  logic [CTR_W-1:0] stall_d_q;
  logic [CTR_W-1:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_i_q <= '0;
      stall_d_q <= '0;
      flush_q   <= '0;
    end else begin
      if (ibusy)         stall_i_q <= stall_i_q + CTR_W'(1);
      if (dbusy)         stall_d_q <= stall_d_q + CTR_W'(1);
      if (redirect_take) flush_q   <= flush_q + CTR_W'(1);
    end
  end

  assign bus.stall_cycles_i = stall_i_q;
  assign bus.stall_cycles_d = stall_d_q;
  assign bus.flush_count    = flush_q;
`else
  assign bus.stall_cycles_i = {CTR_W{1'b0}};
  assign bus.stall_cycles_d = {CTR_W{1'b0}};
  assign bus.flush_count    = {CTR_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Scoreboard bench for pipeline_stall_unit: a behavioural model queues expected outputs per cycle.
module tb_pipeline_stall_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_stall_unit_if bus ();

  pipeline_stall_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [13:0] ctl;
    logic [31:0] si;
    logic [31:0] sd;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: per port, "request outstanding" and "response parked" flags.
  logic        m_iwait, m_idone, m_dwait, m_ddone;
  logic [31:0] m_si, m_sd, m_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic ir, input logic irsp,
                      input logic dr, input logic drsp, input logic redir);
    logic ib, db, adv, run, fl;
    logic [13:0] obs;
    exp_t e, got;
    rst             = r;
    bus.imem_read   = ir;
    bus.imem_resp   = irsp;
    bus.dmem_req    = dr;
    bus.dmem_resp   = drsp;
    bus.ex_redirect = redir;
    if (r) begin
      m_iwait = 1'b0; m_idone = 1'b0; m_dwait = 1'b0; m_ddone = 1'b0;
      m_si = '0; m_sd = '0; m_fc = '0;
    end
    ib  = (m_iwait && !irsp) || (!m_iwait && !m_idone && ir && !irsp);
    db  = (m_dwait && !drsp) || (!m_dwait && !m_ddone && dr && !drsp);
    adv = !ib && !db;
    run = adv && !r;
    fl  = run && redir;
    e.ctl = {run, fl, run, run, run, run, fl, fl,
             m_idone, m_ddone,
             m_iwait && irsp && !adv, m_dwait && drsp && !adv,
             m_idone, m_ddone};
`ifdef PERF_CTR_EN
    e.si = m_si; e.sd = m_sd; e.fc = m_fc;
`else
    e.si = '0; e.sd = '0; e.fc = '0;
`endif
    sb_q.push_back(e);
    if (!r) begin
      m_si    = m_si + {31'd0, ib};
      m_sd    = m_sd + {31'd0, db};
      m_fc    = m_fc + {31'd0, fl};
      m_idone = !adv && (m_idone || (m_iwait && irsp));
      m_ddone = !adv && (m_ddone || (m_dwait && drsp));
      m_iwait = ib;
      m_dwait = db;
    end
    @(negedge clk);
    obs = {bus.pc_ld, bus.pc_redirect, bus.ifid_ld, bus.idex_ld, bus.exmem_ld, bus.memwb_ld,
           bus.ifid_flush, bus.idex_flush, bus.imem_req_mask, bus.dmem_req_mask,
           bus.imem_hold_ld, bus.dmem_hold_ld, bus.imem_use_hold, bus.dmem_use_hold};
    if (sb_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_ctl"}, {18'd0, obs}, {18'd0, got.ctl});
      check({tag, "_stall_i"}, bus.stall_cycles_i, got.si);
      check({tag, "_stall_d"}, bus.stall_cycles_d, got.sd);
      check({tag, "_flush_cnt"}, bus.flush_count, got.fc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] rv;
    rst = 1'b1;
    bus.imem_read = 1'b0; bus.imem_resp = 1'b0; bus.dmem_req = 1'b0;
    bus.dmem_resp = 1'b0; bus.ex_redirect = 1'b0;
    m_iwait = 1'b0; m_idone = 1'b0; m_dwait = 1'b0; m_ddone = 1'b0;
    m_si = '0; m_sd = '0; m_fc = '0;
    @(posedge clk);
    #1;

    step("rst0", 1, 1, 0, 1, 0, 1);
    step("rst1", 1, 1, 1, 1, 1, 1);

    repeat (10) step("hit", 0, 1, 1, 1, 1, 0);

    repeat (3) step("imiss", 0, 1, 0, 0, 0, 0);
    step("imiss_resp", 0, 1, 1, 0, 0, 0);

    repeat (2) step("split_wait", 0, 1, 0, 1, 0, 0);
    step("split_iresp", 0, 1, 1, 1, 0, 0);
    repeat (2) step("split_ihold", 0, 1, 0, 1, 0, 0);
    step("split_dresp", 0, 1, 0, 1, 1, 0);

    repeat (3) step("redir_stall", 0, 0, 0, 1, 0, 1);
    step("redir_take", 0, 0, 0, 1, 1, 1);
    step("redir_after", 0, 1, 1, 0, 0, 0);

    repeat (2) step("mid_wait", 0, 1, 0, 1, 0, 0);
    step("mid_rst", 1, 1, 0, 1, 0, 0);
    step("stray_resp", 0, 0, 1, 0, 1, 0);
    repeat (3) step("recover", 0, 1, 1, 1, 1, 0);

    for (int i = 0; i < 80; i++) begin
      rv = 5'($urandom);
      step("rnd", ($urandom_range(0, 24) == 0), rv[0], rv[1], rv[2], rv[3], rv[4]);
    end

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
